// File: rtl/cp0_intr_pkg.sv
// Shared CP0 definitions: register indices, op encodings, FSM states and
// the bit positions of IE/IP.
package cp0_intr_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_STATUS = 5'd12;
  localparam logic [ADDR_W-1:0] REG_CAUSE  = 5'd13;
  localparam logic [ADDR_W-1:0] REG_EPC    = 5'd14;
  localparam logic [ADDR_W-1:0] REG_EHBR   = 5'd15;

  localparam int unsigned IE_BIT = 0;
  localparam int unsigned IP_BIT = 8;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_MTC0 = 2'd1,
    OP_MFC0 = 2'd2,
    OP_ERET = 2'd3
  } cp0_op_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_HANDLER = 1'b1
  } cp0_state_e;

endpackage

// File: rtl/cp0_intr.sv
// CP0 interrupt controller: STATUS/CAUSE/EPC/EHBR, edge-detected external
// interrupt, and a two-state entry/return FSM driving the PC redirect.
module cp0_intr
  import cp0_intr_pkg::*;
#(
  parameter logic [31:0] EHBR_RST   = 32'h0000_0200,
  parameter logic [31:0] STATUS_RST = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        oper,
  input  logic [ADDR_W-1:0] addr_r,
  output logic [DATA_W-1:0] data_r,
  input  logic [ADDR_W-1:0] addr_w,
  input  logic [DATA_W-1:0] data_w,
  input  logic              ir_en,
  input  logic              ir_in,
  input  logic [DATA_W-1:0] ret_addr,
  output logic              jump_en,
  output logic [DATA_W-1:0] jump_addr
);

  cp0_state_e        state_q, state_d;
  logic              ie_q;
  logic              ip_q;
  logic [DATA_W-1:0] epc_q;
  logic [DATA_W-1:0] ehbr_q;
  logic              ir_q;
  logic              take;
  logic              eret;
  logic              rise;
  cp0_op_e           op;

  assign op   = cp0_op_e'(oper);
  assign rise = ir_in & ~ir_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, take/return decode and combinational redirect outputs
  always_comb begin
    state_d   = state_q;
    take      = 1'b0;
    eret      = 1'b0;
    jump_en   = 1'b0;
    jump_addr = epc_q;
    if (rst) begin
      jump_addr = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          take = ip_q & ie_q & ir_en & en & (op != OP_ERET);
          if (take) begin
            state_d   = ST_HANDLER;
            jump_en   = 1'b1;
            jump_addr = ehbr_q;
          end
        end
        ST_HANDLER: begin
          eret = en & (op == OP_ERET);
          if (eret) begin
            state_d = ST_IDLE;
            jump_en = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Register file; hardware updates are ordered after MTC0 so they win,
  // and an incoming edge on IP is ordered last so set beats clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q   <= STATUS_RST[IE_BIT];
      ip_q   <= 1'b0;
      epc_q  <= '0;
      ehbr_q <= EHBR_RST;
      ir_q   <= 1'b0;
    end else begin
      ir_q <= ir_in;
      if (en && op == OP_MTC0) begin
        unique case (addr_w)
          REG_STATUS: ie_q   <= data_w[IE_BIT];
          REG_CAUSE:  ip_q   <= data_w[IP_BIT];
          REG_EPC:    epc_q  <= {data_w[DATA_W-1:2], 2'b00};
          REG_EHBR:   ehbr_q <= {data_w[DATA_W-1:2], 2'b00};
          default: ;
        endcase
      end
      if (take) begin
        epc_q <= ret_addr;
        ip_q  <= 1'b0;
        ie_q  <= 1'b0;
      end
      if (eret) ie_q <= 1'b1;
      if (rise) ip_q <= 1'b1;
    end
  end

  // Read port reflects register contents at cycle start
  always_comb begin
    data_r = '0;
    unique case (addr_r)
      REG_STATUS: data_r[IE_BIT] = ie_q;
      REG_CAUSE:  data_r[IP_BIT] = ip_q;
      REG_EPC:    data_r = epc_q;
      REG_EHBR:   data_r = ehbr_q;
      default:    data_r = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_intr.sv
// Scoreboard bench for cp0_intr: directed cycles push expected outputs,
// a negedge monitor pops and compares.
module tb_cp0_intr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [1:0]  oper = 2'd0;
  logic [4:0]  addr_r = 5'd0;
  logic [31:0] data_r;
  logic [4:0]  addr_w = 5'd0;
  logic [31:0] data_w = 32'd0;
  logic        ir_en = 1'b1;
  logic        ir_in = 1'b0;
  logic [31:0] ret_addr = 32'd0;
  logic        jump_en;
  logic [31:0] jump_addr;

  typedef struct {
    string       name;
    bit          chk_d;
    logic [31:0] dr;
    logic        je;
    logic [31:0] ja;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  cp0_intr dut (
    .clk(clk), .rst(rst), .en(en), .oper(oper),
    .addr_r(addr_r), .data_r(data_r),
    .addr_w(addr_w), .data_w(data_w),
    .ir_en(ir_en), .ir_in(ir_in), .ret_addr(ret_addr),
    .jump_en(jump_en), .jump_addr(jump_addr)
  );

  always #5 clk = ~clk;

  // Push this cycle's expectation, then advance to just after the next edge
  task automatic cyc(input string nm, input bit cd, input logic [31:0] dr,
                     input logic je, input logic [31:0] ja);
    exp_t e;
    e.name = nm; e.chk_d = cd; e.dr = dr; e.je = je; e.ja = ja;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are combinational, compare mid-cycle
  always @(negedge clk) begin
    if (!done && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (jump_en !== e.je || jump_addr !== e.ja) begin
        errors++;
        $display("FAIL %s jump: got en=%0b addr=%h want en=%0b addr=%h",
                 e.name, jump_en, jump_addr, e.je, e.ja);
      end
      if (e.chk_d) begin
        checks++;
        if (data_r !== e.dr) begin
          errors++;
          $display("FAIL %s data_r: got %h want %h", e.name, data_r, e.dr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    // Reset, even with ERET offered
    oper = 2'd3;
    cyc("rst0", 0, 0, 0, 32'h0);
    cyc("rst1", 0, 0, 0, 32'h0);
    rst = 0; oper = 0;
    addr_r = 12; cyc("rd_status", 1, 32'h1, 0, 32'h0);
    addr_r = 15; cyc("rd_ehbr", 1, 32'h200, 0, 32'h0);
    addr_r = 13; cyc("rd_cause", 1, 32'h0, 0, 32'h0);
    addr_r = 14; cyc("rd_epc", 1, 32'h0, 0, 32'h0);
    addr_r = 3;  cyc("rd_unimpl", 1, 32'h0, 0, 32'h0);
    // Interrupt entry
    ir_in = 1; ret_addr = 32'h40; addr_r = 13;
    cyc("rise", 1, 32'h0, 0, 32'h0);
    cyc("take", 1, 32'h100, 1, 32'h200);
    addr_r = 14; cyc("epc_after", 1, 32'h40, 0, 32'h40);
    addr_r = 12; cyc("ie_after", 1, 32'h0, 0, 32'h40);
    addr_r = 13; cyc("held_level", 1, 32'h0, 0, 32'h40);
    // Second rise inside handler is latched but blocked
    ir_in = 0; cyc("hnd_low", 0, 0, 0, 32'h40);
    ir_in = 1; cyc("hnd_rise", 0, 0, 0, 32'h40);
    cyc("nest_blk", 1, 32'h100, 0, 32'h40);
    oper = 3; cyc("eret", 0, 0, 1, 32'h40);
    oper = 0; ret_addr = 32'h80; addr_r = 12;
    cyc("retake", 1, 32'h1, 1, 32'h200);
    oper = 3; ir_in = 0; cyc("eret2", 0, 0, 1, 32'h80);
    // MTC0 EHBR/EPC with low bits masked
    oper = 1; addr_w = 15; data_w = 32'h1003;
    cyc("mtc0_ehbr", 0, 0, 0, 32'h80);
    oper = 1; addr_w = 14; data_w = 32'h107; addr_r = 15;
    cyc("rd_ehbr_new", 1, 32'h1000, 0, 32'h80);
    oper = 0; addr_r = 14; cyc("rd_epc_new", 1, 32'h104, 0, 32'h104);
    // Stall: rise still detected, no take while en=0
    en = 0; ir_in = 1; cyc("stall_rise", 0, 0, 0, 32'h104);
    addr_r = 13; cyc("stall_hold", 1, 32'h100, 0, 32'h104);
    // Take with concurrent MTC0 STATUS: hardware update wins
    en = 1; ret_addr = 32'h44; oper = 1; addr_w = 12; data_w = 32'h1;
    cyc("take_ehbr", 0, 0, 1, 32'h1000);
    oper = 0; addr_r = 12; cyc("mtc0_lost", 1, 32'h0, 0, 32'h44);
    // Reset during handler
    rst = 1; oper = 3; ir_in = 0; cyc("rst_hnd", 0, 0, 0, 32'h0);
    rst = 0; oper = 0; addr_r = 15; cyc("rst_ehbr", 1, 32'h200, 0, 32'h0);
    addr_r = 12; cyc("rst_ie", 1, 32'h1, 0, 32'h0);
    // IE masking
    oper = 1; addr_w = 12; data_w = 32'h0; cyc("mtc0_ie0", 0, 0, 0, 32'h0);
    oper = 0; ir_in = 1; cyc("rise_masked", 0, 0, 0, 32'h0);
    addr_r = 13; cyc("masked_pend", 1, 32'h100, 0, 32'h0);
    oper = 1; addr_w = 12; data_w = 32'hFFFF_FFFF; ret_addr = 32'h10;
    cyc("mtc0_ie1", 0, 0, 0, 32'h0);
    oper = 0; addr_r = 12; cyc("take_unmask", 1, 32'h1, 1, 32'h200);
    oper = 3; cyc("eret3", 0, 0, 1, 32'h10);
    ir_in = 0; cyc("eret_idle", 0, 0, 0, 32'h10);
    // Rise coincident with take: IP stays set
    oper = 0; en = 0; ir_in = 1; cyc("pre_rise", 0, 0, 0, 32'h10);
    ir_in = 0; cyc("pre_low", 0, 0, 0, 32'h10);
    en = 1; ir_in = 1; ret_addr = 32'h20;
    cyc("take_rise", 0, 0, 1, 32'h200);
    addr_r = 13; cyc("ip_kept", 1, 32'h100, 0, 32'h20);
    @(posedge clk); #1;
    done = 1'b1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
